// File: rtl/qbert_cmd_if.sv
// Avalon-MM slave bus between the NIOS and the Qbert command scheduler.
// The NIOS side (or a testbench) uses the master modport; the scheduler uses slave.
interface qbert_cmd_if;
    logic [1:0]  Avalon_address;
    logic        Avalon_write;
    logic [31:0] Avalon_writedata;
    logic        Avalon_read;
    logic [31:0] Avalon_readdata;

    modport master (
        output Avalon_address,
        output Avalon_write,
        output Avalon_writedata,
        output Avalon_read,
        input  Avalon_readdata
    );

    modport slave (
        input  Avalon_address,
        input  Avalon_write,
        input  Avalon_writedata,
        input  Avalon_read,
        output Avalon_readdata
    );
endinterface

// File: rtl/qbert_cmd_scheduler.sv
// Frame-synchronous command scheduler: NIOS pushes game commands into a FIFO,
// one command is issued per LCD frame as a fixed-width strobe; jumps then wait
// for the engine's move-done (or a timeout) before the next command may go.
module qbert_cmd_scheduler #(
    parameter int DEPTH        = 4,
    parameter int PULSE_CYCLES = 4,
    parameter int TIMEOUT      = 50_000_000
) (
    input  logic        Avalon_CLK_50,
    input  logic        iRST_n,
    qbert_cmd_if.slave  avs,
    input  logic        iFrameToggle,
    input  logic        iDoneMove,
    output logic        oStart,
    output logic        oPause,
    output logic        oResume,
    output logic        oJump,
    output logic [2:0]  oJumpDir,
    output logic        oBusy,
    output logic        oIrq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(PULSE_CYCLES + 1);

    localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYCLES);
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [25:0]   WAIT_LAST  = 26'(TIMEOUT - 1);
    localparam logic [25:0]   WAIT_MAX   = 26'h3FF_FFFF;

    localparam logic [2:0] OP_START  = 3'd1;
    localparam logic [2:0] OP_PAUSE  = 3'd2;
    localparam logic [2:0] OP_RESUME = 3'd3;
    localparam logic [2:0] OP_JUMP   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_ISSUE      = 2'd2,
        ST_WAIT_DONE  = 2'd3
    } state_t;

    // Only the four game opcodes are accepted into the FIFO.
    function automatic logic is_legal_op(input logic [2:0] op);
        case (op)
            OP_START, OP_PAUSE, OP_RESUME, OP_JUMP: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    // Synchroniser chains and their edge-detect history
    logic frame_meta_q, frame_sync_q, frame_prev_q;
    logic done_meta_q,  done_sync_q,  done_prev_q;
    logic frame_evt_s, done_rise_s;

    // Bus decode
    logic       cmd_wr_s, ctrl_wr_s, flush_s, clr_s, legal_s;
    logic [2:0] op_in_s, dir_in_s;

    // FIFO
    logic [5:0]    fifo_mem_q [DEPTH];
    logic [5:0]    fifo_mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_s, empty_s, push_s, pop_s;
    logic [5:0]    head_s;

    // FSM and its counters / command register
    state_t        state_q, state_d;
    logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [25:0]   wait_cnt_q, wait_cnt_d;
    logic [2:0]    cmd_op_q, cmd_op_d, cmd_dir_q, cmd_dir_d;
    logic          done_set_s, tmo_set_s, ovf_set_s, ill_set_s;

    // Sticky bits and registered outputs
    logic        ovf_q, ovf_d, ill_q, ill_d, done_q, done_d, tmo_q, tmo_d;
    logic        start_q, start_d, pause_q, pause_d, resume_q, resume_d, jump_q, jump_d;
    logic [2:0]  jump_dir_q, jump_dir_d;
    logic        busy_q, busy_d, irq_q, irq_d;
    logic [31:0] rdata_q, rdata_d, status_s;

    // Two-flop synchronisers plus one history flop each for edge detection
    always_ff @(posedge Avalon_CLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            frame_meta_q <= 1'b0;
            frame_sync_q <= 1'b0;
            frame_prev_q <= 1'b0;
            done_meta_q  <= 1'b0;
            done_sync_q  <= 1'b0;
            done_prev_q  <= 1'b0;
        end else begin
            frame_meta_q <= iFrameToggle;
            frame_sync_q <= frame_meta_q;
            frame_prev_q <= frame_sync_q;
            done_meta_q  <= iDoneMove;
            done_sync_q  <= done_meta_q;
            done_prev_q  <= done_sync_q;
        end
    end

    assign frame_evt_s = frame_sync_q ^ frame_prev_q;
    assign done_rise_s = done_sync_q & ~done_prev_q;

    assign cmd_wr_s  = avs.Avalon_write && (avs.Avalon_address == 2'd0);
    assign ctrl_wr_s = avs.Avalon_write && (avs.Avalon_address == 2'd2);
    assign flush_s   = ctrl_wr_s && avs.Avalon_writedata[0];
    assign clr_s     = ctrl_wr_s && avs.Avalon_writedata[1];
    assign op_in_s   = avs.Avalon_writedata[2:0];
    assign dir_in_s  = avs.Avalon_writedata[6:4];
    assign legal_s   = is_legal_op(op_in_s);

    assign full_s  = (count_q == FULL_CNT);
    assign empty_s = (count_q == {CW{1'b0}});
    assign head_s  = fifo_mem_q[rd_ptr_q];
    // A pop frees a slot in the same cycle, so a push to a full FIFO still fits.
    assign pop_s     = (state_q == ST_IDLE) && !empty_s;
    assign push_s    = cmd_wr_s && legal_s && (!full_s || pop_s) && !flush_s;
    assign ovf_set_s = cmd_wr_s && legal_s && full_s && !pop_s && !flush_s;
    assign ill_set_s = cmd_wr_s && !legal_s;

    // FIFO next state: flush wins over push/pop bookkeeping
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (flush_s) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_s) begin
                fifo_mem_d[wr_ptr_q] = {dir_in_s, op_in_s};
                wr_ptr_d             = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO storage and pointers
    always_ff @(posedge Avalon_CLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem_q[i] <= 6'd0;
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            fifo_mem_q <= fifo_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // FSM next state, counters and command register
    always_comb begin
        state_d     = state_q;
        pulse_cnt_d = pulse_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        cmd_op_d    = cmd_op_q;
        cmd_dir_d   = cmd_dir_q;
        done_set_s  = 1'b0;
        tmo_set_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    cmd_op_d  = head_s[2:0];
                    cmd_dir_d = head_s[5:3];
                    state_d   = ST_WAIT_FRAME;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_FRAME: begin
                if (frame_evt_s) begin
                    pulse_cnt_d = PULSE_LOAD;
                    state_d     = ST_ISSUE;
                end else begin
                    state_d = ST_WAIT_FRAME;
                end
            end
            ST_ISSUE: begin
                if (pulse_cnt_q <= PW'(1)) begin
                    if (cmd_op_q == OP_JUMP) begin
                        wait_cnt_d = 26'd0;
                        state_d    = ST_WAIT_DONE;
                    end else begin
                        done_set_s = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end else begin
                    pulse_cnt_d = pulse_cnt_q - PW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (done_rise_s) begin
                    done_set_s = 1'b1;
                    state_d    = ST_IDLE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    tmo_set_s = 1'b1;
                    state_d   = ST_IDLE;
                end else if (wait_cnt_q != WAIT_MAX) begin
                    wait_cnt_d = wait_cnt_q + 26'd1;
                end else begin
                    wait_cnt_d = wait_cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register, counters and latched command
    always_ff @(posedge Avalon_CLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q     <= ST_IDLE;
            pulse_cnt_q <= {PW{1'b0}};
            wait_cnt_q  <= 26'd0;
            cmd_op_q    <= 3'd0;
            cmd_dir_q   <= 3'd0;
        end else begin
            state_q     <= state_d;
            pulse_cnt_q <= pulse_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            cmd_op_q    <= cmd_op_d;
            cmd_dir_q   <= cmd_dir_d;
        end
    end

    // Sticky bits (set beats clear), output decode from next state, read mux
    always_comb begin
        ovf_d  = ovf_set_s  ? 1'b1 : (clr_s ? 1'b0 : ovf_q);
        ill_d  = ill_set_s  ? 1'b1 : (clr_s ? 1'b0 : ill_q);
        done_d = done_set_s ? 1'b1 : (clr_s ? 1'b0 : done_q);
        tmo_d  = tmo_set_s  ? 1'b1 : (clr_s ? 1'b0 : tmo_q);
        irq_d  = done_d | tmo_d;
        busy_d = (state_d != ST_IDLE);

        // Decoding from the next state keeps strobes aligned with ISSUE.
        start_d  = (state_d == ST_ISSUE) && (cmd_op_d == OP_START);
        pause_d  = (state_d == ST_ISSUE) && (cmd_op_d == OP_PAUSE);
        resume_d = (state_d == ST_ISSUE) && (cmd_op_d == OP_RESUME);
        jump_d   = (state_d == ST_ISSUE) && (cmd_op_d == OP_JUMP);
        if (((state_d == ST_ISSUE) || (state_d == ST_WAIT_DONE)) && (cmd_op_d == OP_JUMP)) begin
            jump_dir_d = cmd_dir_d;
        end else begin
            jump_dir_d = 3'd0;
        end

        status_s        = 32'd0;
        status_s[3:0]   = 4'(count_q);
        status_s[4]     = full_s;
        status_s[5]     = empty_s;
        status_s[6]     = (state_q != ST_IDLE);
        status_s[8]     = ovf_q;
        status_s[9]     = ill_q;
        status_s[10]    = done_q;
        status_s[11]    = tmo_q;
        status_s[14:12] = {1'b0, state_q};

        rdata_d = rdata_q;
        if (avs.Avalon_read) begin
            case (avs.Avalon_address)
                2'd1:    rdata_d = status_s;
                2'd3:    rdata_d = {6'd0, wait_cnt_q};
                default: rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Sticky bits and all registered outputs
    always_ff @(posedge Avalon_CLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            ovf_q      <= 1'b0;
            ill_q      <= 1'b0;
            done_q     <= 1'b0;
            tmo_q      <= 1'b0;
            start_q    <= 1'b0;
            pause_q    <= 1'b0;
            resume_q   <= 1'b0;
            jump_q     <= 1'b0;
            jump_dir_q <= 3'd0;
            busy_q     <= 1'b0;
            irq_q      <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            ovf_q      <= ovf_d;
            ill_q      <= ill_d;
            done_q     <= done_d;
            tmo_q      <= tmo_d;
            start_q    <= start_d;
            pause_q    <= pause_d;
            resume_q   <= resume_d;
            jump_q     <= jump_d;
            jump_dir_q <= jump_dir_d;
            busy_q     <= busy_d;
            irq_q      <= irq_d;
            rdata_q    <= rdata_d;
        end
    end

    assign oStart              = start_q;
    assign oPause              = pause_q;
    assign oResume             = resume_q;
    assign oJump               = jump_q;
    assign oJumpDir            = jump_dir_q;
    assign oBusy               = busy_q;
    assign oIrq                = irq_q;
    assign avs.Avalon_readdata = rdata_q;

endmodule

// File: tb/tb_qbert_cmd_scheduler.sv
// Scoreboard bench for qbert_cmd_scheduler: stimulus pushes expected strobes
// and expected read data into queues; a negedge monitor pops and compares.
module tb_qbert_cmd_scheduler;

    localparam int PULSE = 4;
    localparam int TO    = 2000;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       frame_tgl = 1'b0;
    logic       done_mv   = 1'b0;
    logic       o_start, o_pause, o_resume, o_jump, o_busy, o_irq;
    logic [2:0] o_dir;

    qbert_cmd_if bus ();

    qbert_cmd_scheduler #(
        .DEPTH        (4),
        .PULSE_CYCLES (PULSE),
        .TIMEOUT      (TO)
    ) dut (
        .Avalon_CLK_50 (clk),
        .iRST_n        (rst_n),
        .avs           (bus),
        .iFrameToggle  (frame_tgl),
        .iDoneMove     (done_mv),
        .oStart        (o_start),
        .oPause        (o_pause),
        .oResume       (o_resume),
        .oJump         (o_jump),
        .oJumpDir      (o_dir),
        .oBusy         (o_busy),
        .oIrq          (o_irq)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int op; int dir; } strobe_t;
    typedef struct { logic [31:0] val; string name; } rd_t;
    strobe_t exp_q [$];
    rd_t     rd_q  [$];

    int n_checks = 0;
    int n_pass   = 0;
    int last_frame_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    endtask

    // Monitor: read responses one cycle after a read; strobe rise/fall checks
    logic [3:0] prev_s = 4'b0;
    logic [3:0] m_s;
    int         hi_cnt [4];
    logic       rd_prev = 1'b0;
    rd_t        m_r;
    strobe_t    m_e;

    always @(negedge clk) begin
        if (rd_prev) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                $display("FAIL rd_unexpected: got read response 0x%0h, required none", bus.Avalon_readdata);
            end else begin
                m_r = rd_q.pop_front();
                check(m_r.name, bus.Avalon_readdata, m_r.val);
            end
        end
        rd_prev = bus.Avalon_read;

        m_s = {o_jump, o_resume, o_pause, o_start};
        if (!rst_n) begin
            prev_s = 4'b0;
            for (int i = 0; i < 4; i++) hi_cnt[i] = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (m_s[i] && !prev_s[i]) begin
                    hi_cnt[i] = 1;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL strobe_unexpected: got strobe op %0d, required none", i + 1);
                    end else begin
                        m_e = exp_q.pop_front();
                        check("strobe_op", i + 1, m_e.op);
                        check("one_hot", $countones(m_s), 1);
                        check_rng("frame_latency", cyc - last_frame_cyc, 2, 4);
                        if (m_e.op == 4) check("jump_dir", {29'd0, o_dir}, m_e.dir);
                    end
                end else if (m_s[i] && prev_s[i]) begin
                    hi_cnt[i]++;
                end else if (!m_s[i] && prev_s[i]) begin
                    check("strobe_width", hi_cnt[i], PULSE);
                end
            end
            prev_s = m_s;
        end
    end

    // Stimulus helpers: all start and end at posedge + 1
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.Avalon_address   = a;
        bus.Avalon_writedata = d;
        bus.Avalon_write     = 1'b1;
        @(posedge clk); #1;
        bus.Avalon_write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        rd_t r;
        r.val  = exp;
        r.name = name;
        rd_q.push_back(r);
        bus.Avalon_address = a;
        bus.Avalon_read    = 1'b1;
        @(posedge clk); #1;
        bus.Avalon_read = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic frame();
        frame_tgl      = ~frame_tgl;
        last_frame_cyc = cyc;
    endtask

    task automatic expect_strobe(input int op, input int dir);
        strobe_t e;
        e.op  = op;
        e.dir = dir;
        exp_q.push_back(e);
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return o_start;
            1:       return o_pause;
            2:       return o_resume;
            3:       return o_jump;
            4:       return o_busy;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int which, input logic lvl, input int max, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (sig(which) == lvl) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL %s: got timeout after %0d cycles, required level %0b", name, max, lvl);
        end
    endtask

    int t0;
    bit dir_bad;

    initial begin
        bus.Avalon_address   = 2'd0;
        bus.Avalon_write     = 1'b0;
        bus.Avalon_writedata = 32'd0;
        bus.Avalon_read      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {o_start, o_pause, o_resume, o_jump, o_dir, o_busy, o_irq}, 32'd0);
        check("reset_readdata", bus.Avalon_readdata, 32'd0);
        rst_n = 1'b1;
        idle(2);
        rd(2'd1, 32'h0000_0020, "status_after_reset");

        // START then RESUME, one per frame
        expect_strobe(1, 0);
        expect_strobe(3, 0);
        wr(2'd0, 32'h1);
        wr(2'd0, 32'h3);
        idle(3);
        frame();
        idle(15);
        frame();
        idle(15);
        rd(2'd1, 32'h0000_0420, "t1_status_done");
        check("t1_irq", o_irq, 1'b1);
        wr(2'd2, 32'h2);
        check("t1_irq_clr", o_irq, 1'b0);
        rd(2'd1, 32'h0000_0020, "t1_status_clr");

        // JUMP dir 5 completed by move-done
        expect_strobe(4, 5);
        wr(2'd0, 32'h54);
        idle(3);
        frame();
        wait_for(3, 1'b1, 10, "t2_jump_rise");
        wait_for(3, 1'b0, 10, "t2_jump_fall");
        dir_bad = 1'b0;
        repeat (1000) begin
            if (o_dir !== 3'd5 || o_busy !== 1'b1) dir_bad = 1'b1;
            @(posedge clk); #1;
        end
        check("t2_dir_held", dir_bad, 1'b0);
        done_mv = 1'b1;
        t0 = cyc;
        wait_for(4, 1'b0, 10, "t2_idle");
        check_rng("t2_done_latency", cyc - t0, 2, 4);
        check("t2_irq", o_irq, 1'b1);
        rd(2'd1, 32'h0000_0420, "t2_status_done");
        wr(2'd2, 32'h2);
        check("t2_irq_clr", o_irq, 1'b0);
        done_mv = 1'b0;
        idle(3);

        // JUMP times out, queued START goes on the next frame
        expect_strobe(4, 2);
        expect_strobe(1, 0);
        wr(2'd0, 32'h24);
        wr(2'd0, 32'h1);
        idle(3);
        frame();
        wait_for(3, 1'b1, 10, "t3_jump_rise");
        wait_for(3, 1'b0, 10, "t3_jump_fall");
        t0 = cyc;
        wait_for(4, 1'b0, TO + 20, "t3_timeout");
        check("t3_tmo_cycles", cyc - t0, TO);
        check("t3_irq", o_irq, 1'b1);
        idle(2);
        rd(2'd1, 32'h0000_1860, "t3_status_tmo");
        rd(2'd3, TO - 1, "t3_wait_cnt");
        frame();
        idle(15);
        wr(2'd2, 32'h2);
        rd(2'd1, 32'h0000_0020, "t3_status_clr");

        // Overflow, illegal opcode, flush keeps in-flight command
        expect_strobe(1, 0);
        wr(2'd0, 32'h1);
        wr(2'd0, 32'h2);
        wr(2'd0, 32'h3);
        wr(2'd0, 32'h74);
        wr(2'd0, 32'h2);
        wr(2'd0, 32'h3);
        rd(2'd1, 32'h0000_1154, "t4_status_ovf");
        wr(2'd0, 32'h0);
        rd(2'd1, 32'h0000_1354, "t4_status_ill");
        wr(2'd2, 32'h1);
        rd(2'd1, 32'h0000_1360, "t4_status_flush");
        frame();
        idle(15);
        wr(2'd2, 32'h2);
        rd(2'd1, 32'h0000_0020, "t4_status_end");

        // Full FIFO with simultaneous pop and push, then reset during ISSUE
        expect_strobe(1, 0);
        wr(2'd0, 32'h1);
        wr(2'd0, 32'h2);
        wr(2'd0, 32'h3);
        wr(2'd0, 32'h1);
        wr(2'd0, 32'h2);
        rd(2'd1, 32'h0000_1054, "t5_status_full");
        frame();
        wait_for(0, 1'b1, 10, "t5_start_rise");
        wait_for(0, 1'b0, 10, "t5_start_fall");
        wr(2'd0, 32'h3);
        idle(1);
        rd(2'd1, 32'h0000_1454, "t5_status_pushpop");
        expect_strobe(2, 0);
        frame();
        wait_for(1, 1'b1, 10, "t5_pause_rise");
        idle(1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_outputs", {o_start, o_pause, o_resume, o_jump, o_busy, o_irq}, 32'd0);
        check("t5_rst_readdata", bus.Avalon_readdata, 32'd0);
        idle(3);
        rst_n = 1'b1;
        idle(2);
        rd(2'd1, 32'h0000_0020, "t5_status_after_rst");
        idle(3);

        check("strobes_outstanding", exp_q.size(), 32'd0);
        check("reads_outstanding", rd_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion by 1 ms, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
